router_rr_arbiter_mux: RTL and testbench

//  Output-port arbiter plus data mux for the router. Selects one of NUM input FIFOs
//  (first-word-fall-through) with data pending, pops it, and registers the packet into a

---
 rtl/router_arb_pkg.sv | 31 +++
 rtl/router_rr_arbiter_mux_sva.sv | 25 ++
 rtl/router_rr_pick.sv | 24 ++
 rtl/router_rr_arbiter_mux.sv | 111 +++++++++++
 tb/tb_router_rr_arbiter_mux.sv | 137 +++++++++++++
 5 files changed

// File: rtl/router_arb_pkg.sv
// Shared types and helpers for the router output-port arbiter.
// first_from() is a rotating search used by the round-robin picker.
package router_arb_pkg;

   typedef enum logic {ARB_RR = 1'b0, ARB_FIXED = 1'b1} arb_mode_e;

   localparam int ARB_PKT_W = 40;
   localparam int ARB_MAX_N = 32;

   typedef logic [ARB_PKT_W-1:0] pkt_t;

   // Index of the first set bit of req at or above ptr, wrapping at n; 0 if none.
   function automatic int first_from(input logic [ARB_MAX_N-1:0] req,
                                     input int n, input int ptr);
      int   idx;
      logic found;
      first_from = 0;
      found      = 1'b0;
      for (int i = 0; i < ARB_MAX_N; i++) begin
         if (i < n) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && req[idx]) begin
               first_from = idx;
               found      = 1'b1;
            end
         end
      end
   endfunction

endpackage

// File: rtl/router_rr_arbiter_mux_sva.sv
// Invariant checks for the arbiter: legal one-hot pops, push rule, held output.
module router_rr_arbiter_mux_sva #(
   parameter int NUM     = 4,
   parameter int PCKG_SZ = 40,
   parameter int IDX_W   = $clog2(NUM)
) (
   input logic               clk,
   input logic               reset,
   input logic [NUM-1:0]     req,
   input logic [NUM-1:0]     pop,
   input logic               push,
   input logic               out_valid,
   input logic               full,
   input logic [PCKG_SZ-1:0] data_in,
   input logic [IDX_W-1:0]   trn
);

   a_pop_onehot : assert property (@(posedge clk) $onehot0(pop));
   a_pop_legal  : assert property (@(posedge clk) (pop & ~req) == '0);
   a_pop_rst    : assert property (@(posedge clk) reset |-> (pop == '0));
   a_push_rule  : assert property (@(posedge clk) push == (out_valid & ~full));
   a_hold       : assert property (@(posedge clk) disable iff (reset)
                     (out_valid && full) |=> ($stable(data_in) && $stable(trn)));

endmodule

// File: rtl/router_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after ptr_i.
module router_rr_pick
   import router_arb_pkg::*;
#(
   parameter int NUM   = 4,
   parameter int IDX_W = $clog2(NUM)
) (
   input  logic [NUM-1:0]   req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [NUM-1:0]   gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   always_comb begin
      int k;
      k     = first_from(ARB_MAX_N'(req_i), NUM, int'(ptr_i));
      any_o = |req_i;
      idx_o = IDX_W'(k);
      gnt_o = '0;
      if (any_o) gnt_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/router_rr_arbiter_mux.sv
// Output-port arbiter + data mux: picks one pending FIFO (RR or fixed priority,
// with burst lock), pops it and holds the packet in a one-entry output stage.
module router_rr_arbiter_mux
   import router_arb_pkg::*;
#(
   parameter int NUM       = 4,
   parameter int PCKG_SZ   = 40,
   parameter int MAX_BURST = 1,
   parameter int BCNT_W    = $clog2(MAX_BURST + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        mode_i,
   input  logic [NUM-1:0]              en_i,
   input  logic [NUM-1:0]              pndng_i,
   input  logic [NUM-1:0][PCKG_SZ-1:0] data_out_i,
   output logic [NUM-1:0]              pop,
   input  logic                        full_i,
   output logic                        push,
   output logic [PCKG_SZ-1:0]          data_in,
   output logic [$clog2(NUM)-1:0]      trn
);

   localparam int IDX_W = $clog2(NUM);

   logic               out_valid_q;
   logic [PCKG_SZ-1:0] data_q;
   logic [IDX_W-1:0]   trn_q, rr_ptr_q, last_g_q;
   logic [BCNT_W-1:0]  bcnt_q, bcnt_nxt;
   arb_mode_e          mode_q, mode_cur;

   logic [NUM-1:0]     req, pick_oh;
   logic [IDX_W-1:0]   pick_ptr, pick_idx, g, g_nxt;
   logic               pick_any, can_grant, grant, lock_ok;

   assign mode_cur  = arb_mode_e'(mode_i);
   assign req       = pndng_i & en_i;
   assign push      = out_valid_q & ~full_i;
   assign can_grant = ~out_valid_q | push;

   // Lock only survives while RR was in force last cycle and the holder still requests.
   assign lock_ok   = (mode_cur == ARB_RR) && (mode_q == ARB_RR) && (bcnt_q != '0) &&
                      req[last_g_q] && (bcnt_q < BCNT_W'(MAX_BURST));
   assign pick_ptr  = (mode_cur == ARB_FIXED) ? '0 : rr_ptr_q;

   router_rr_pick #(.NUM(NUM), .IDX_W(IDX_W)) u_pick (
      .req_i (req),
      .ptr_i (pick_ptr),
      .gnt_o (pick_oh),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   assign grant    = can_grant & pick_any & ~reset;
   assign g        = lock_ok ? last_g_q : pick_idx;
   assign g_nxt    = (g == IDX_W'(NUM - 1)) ? '0 : g + 1'b1;
   assign bcnt_nxt = lock_ok ? bcnt_q + 1'b1 : BCNT_W'(1);

   always_comb begin
      pop = '0;
      if (grant) begin
         if (lock_ok) pop[last_g_q] = 1'b1;
         else         pop = pick_oh;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         data_q      <= '0;
         trn_q       <= '0;
         rr_ptr_q    <= '0;
         last_g_q    <= '0;
         bcnt_q      <= '0;
         mode_q      <= ARB_RR;
      end else begin
         mode_q <= mode_cur;
         if (push) out_valid_q <= 1'b0;
         if (grant) begin
            out_valid_q <= 1'b1;
            data_q      <= data_out_i[g];
            trn_q       <= g;
         end
         if (mode_cur == ARB_RR) begin
            if (grant) begin
               last_g_q <= g;
               rr_ptr_q <= g_nxt;
               bcnt_q   <= (bcnt_nxt >= BCNT_W'(MAX_BURST)) ? '0 : bcnt_nxt;
            end else if (bcnt_q != '0 && (!req[last_g_q] || mode_q == ARB_FIXED)) begin
               bcnt_q <= '0;
            end
         end
      end
   end

   assign data_in = data_q;
   assign trn     = trn_q;

   router_rr_arbiter_mux_sva #(.NUM(NUM), .PCKG_SZ(PCKG_SZ), .IDX_W(IDX_W)) u_sva (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .pop       (pop),
      .push      (push),
      .out_valid (out_valid_q),
      .full      (full_i),
      .data_in   (data_in),
      .trn       (trn)
   );

endmodule

// File: tb/tb_router_rr_arbiter_mux.sv
// Directed bench: one instance with MAX_BURST=1 (d1) and one with MAX_BURST=3 (d3).
module tb_router_rr_arbiter_mux;

   logic              clk = 1'b0;
   logic              reset, mode, full;
   logic [3:0]        en, pndng;
   logic [3:0][39:0]  dout;
   logic [3:0]        pop1, pop3;
   logic              push1, push3;
   logic [39:0]       din1, din3;
   logic [1:0]        trn1, trn3;
   int                total = 0, bad = 0;

   always #5 clk = ~clk;

   router_rr_arbiter_mux #(.NUM(4), .PCKG_SZ(40), .MAX_BURST(1)) d1 (
      .clk(clk), .reset(reset), .mode_i(mode), .en_i(en), .pndng_i(pndng),
      .data_out_i(dout), .pop(pop1), .full_i(full), .push(push1),
      .data_in(din1), .trn(trn1));

   router_rr_arbiter_mux #(.NUM(4), .PCKG_SZ(40), .MAX_BURST(3)) d3 (
      .clk(clk), .reset(reset), .mode_i(mode), .en_i(en), .pndng_i(pndng),
      .data_out_i(dout), .pop(pop3), .full_i(full), .push(push3),
      .data_in(din3), .trn(trn3));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Pulse reset for one cycle, release with the given pending vector, settle.
   task automatic do_reset(input logic [3:0] pn);
      @(negedge clk); reset = 1'b1; pndng = 4'h0;
      @(negedge clk); reset = 1'b0; pndng = pn;
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] seq4 [7];
      seq4 = '{2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd1};
      reset = 1'b1; mode = 1'b0; full = 1'b0; en = 4'hF; pndng = 4'hF;
      for (int k = 0; k < 4; k++) dout[k] = 40'hD0 + 40'(k);

      // 1: reset held with all ports pending
      @(negedge clk); @(negedge clk); #1;
      chk("rst_pop1", 64'(pop1), 64'h0);
      chk("rst_pop3", 64'(pop3), 64'h0);
      chk("rst_push", 64'(push1), 64'h0);
      chk("rst_trn", 64'(trn1), 64'h0);
      chk("rst_din", 64'(din1), 64'h0);
      @(negedge clk); reset = 1'b0; #1;
      chk("rel_push", 64'(push1), 64'h0);
      chk("rel_trn", 64'(trn1), 64'h0);
      chk("rel_pop", 64'(pop1), 64'h1);

      // 2: plain RR, one packet per cycle
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         chk("rr_push", 64'(push1), 64'h1);
         chk("rr_trn", 64'(trn1), 64'(i % 4));
         chk("rr_din", 64'(din1), 64'h0D0 + 64'(i % 4));
      end

      // 3: back-pressure holds the A5 packet from port 2
      dout[2] = 40'hA5;
      do_reset(4'b0100);
      chk("bp_pop_first", 64'(pop1), 64'h4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); pndng = 4'b0001; full = 1'b1; #1;
         chk("bp_push", 64'(push1), 64'h0);
         chk("bp_din", 64'(din1), 64'hA5);
         chk("bp_trn", 64'(trn1), 64'h2);
         chk("bp_pop", 64'(pop1), 64'h0);
      end
      @(negedge clk); full = 1'b0; #1;
      chk("bp_rel_push", 64'(push1), 64'h1);
      chk("bp_rel_pop", 64'(pop1), 64'h1);
      @(negedge clk); pndng = 4'h0; #1;
      chk("bp_next_trn", 64'(trn1), 64'h0);
      chk("bp_next_din", 64'(din1), 64'hD0);
      chk("bp_next_push", 64'(push1), 64'h1);

      // 4: burst lock of 3 on ports 1 and 3
      do_reset(4'b1010);
      chk("bl_pop_first", 64'(pop3), 64'h2);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); #1;
         chk("bl_trn", 64'(trn3), 64'(seq4[i]));
         chk("bl_push", 64'(push3), 64'h1);
      end
      do_reset(4'b1010);
      @(negedge clk); pndng = 4'b1000; #1;
      chk("bl_drop_trn", 64'(trn3), 64'h1);
      chk("bl_drop_pop", 64'(pop3), 64'h8);
      @(negedge clk); #1;
      chk("bl_drop_next", 64'(trn3), 64'h3);

      // 5: fixed priority with enable masking
      mode = 1'b1; en = 4'b1101;
      do_reset(4'b1010);
      chk("fp_pop_masked", 64'(pop1), 64'h8);
      @(negedge clk); en = 4'hF; #1;
      chk("fp_trn_masked", 64'(trn1), 64'h3);
      chk("fp_pop_en", 64'(pop1), 64'h2);
      @(negedge clk); #1;
      chk("fp_trn_en", 64'(trn1), 64'h1);
      @(negedge clk); #1;
      chk("fp_trn_again", 64'(trn1), 64'h1);

      // 6: reset while a packet is stuck behind full
      mode = 1'b0; full = 1'b1;
      do_reset(4'b0100);
      @(negedge clk); pndng = 4'h0; #1;
      chk("rm_push_full", 64'(push1), 64'h0);
      chk("rm_trn_held", 64'(trn1), 64'h2);
      @(negedge clk); reset = 1'b1; #1;
      chk("rm_pop_in_rst", 64'(pop1), 64'h0);
      @(negedge clk); reset = 1'b0; full = 1'b0; pndng = 4'hF; #1;
      chk("rm_push", 64'(push1), 64'h0);
      chk("rm_din", 64'(din1), 64'h0);
      chk("rm_trn", 64'(trn1), 64'h0);
      chk("rm_ptr", 64'(pop1), 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
